// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO owner with serial multiply/divide sequencer
// Purpose: runs MULT/MULTU/DIV/DIVU on a radix-2 serial datapath, services
//   mthi/mtlo, and requests a pipeline stall while an operation is in flight.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   start_i, op_i       launch request and operation (0 MULT,1 MULTU,2 DIV,3 DIVU)
//   op_a_i, op_b_i      rs / rt operands
//   hi_we_i, lo_we_i    mthi / mtlo write enables, data on wr_data_i
//   read_hilo_i         EX holds mfhi/mflo
//   flush_i             squash in-flight operation
//   hi_o, lo_o          registered HI/LO
//   busy_o, done_o      operation in flight / one-cycle completion pulse
//   stall_req_o         busy & (start | read | hi write | lo write)
// Option: HILO_FAST_MUL_EN selects a single-cycle multiplier for MULT/MULTU.
module hilo_muldiv_ctrl #(
   parameter int ITER = 32
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        hi_we_i,
   input  logic        lo_we_i,
   input  logic [31:0] wr_data_i,
   input  logic        read_hilo_i,
   input  logic        flush_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        stall_req_o
);

   localparam int CW = $clog2(ITER) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t        state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [31:0]   a_q, a_d;       // multiplicand, or dividend shifted out MSB-first
   logic [31:0]   b_q, b_d;       // multiplier shifted out LSB-first, or divisor
   logic [63:0]   acc_q, acc_d;   // product, or remainder:quotient
   logic [CW-1:0] cnt_q, cnt_d;
   logic          negq_q, negq_d;
   logic          negr_q, negr_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic          done_q, done_d;

   logic          is_signed;
   logic [32:0]   mul_sum;
   logic [32:0]   div_sh;
   logic [33:0]   div_diff;

   assign is_signed = ~op_i[0];
   assign mul_sum   = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
   assign div_sh    = {acc_q[63:32], a_q[31]};
   assign div_diff  = {1'b0, div_sh} - {2'b00, b_q};

`ifdef HILO_FAST_MUL_EN
   logic [63:0] fast_prod;
   // Sign-extending to 64 bits lets one unsigned multiply serve both forms.
   assign fast_prod = {{32{is_signed & op_a_i[31]}}, op_a_i} *
                      {{32{is_signed & op_b_i[31]}}, op_b_i};
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (hi_we_i) hi_d = wr_data_i;
            if (lo_we_i) lo_d = wr_data_i;
            if (start_i && !flush_i) begin
               op_d   = op_i;
               a_d    = (is_signed && op_a_i[31]) ? -op_a_i : op_a_i;
               b_d    = (is_signed && op_b_i[31]) ? -op_b_i : op_b_i;
               negq_d = is_signed & (op_a_i[31] ^ op_b_i[31]);
               negr_d = is_signed & op_a_i[31];
               // Divide by zero: a raw dividend with no correction leaves
               // remainder = opA and quotient = all ones from the serial path.
               if (op_i[1] && op_b_i == 32'd0) begin
                  a_d    = op_a_i;
                  negq_d = 1'b0;
                  negr_d = 1'b0;
               end
               acc_d   = 64'd0;
               cnt_d   = '0;
               state_d = CALC;
`ifdef HILO_FAST_MUL_EN
               if (!op_i[1]) begin
                  acc_d   = fast_prod;
                  negq_d  = 1'b0;
                  negr_d  = 1'b0;
                  state_d = FIX;
               end
`endif
            end
         end
         CALC: begin
            if (op_q[1]) begin
               a_d = {a_q[30:0], 1'b0};
               if (!div_diff[33]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
               else               acc_d = {div_sh[31:0], acc_q[30:0], 1'b0};
            end else begin
               acc_d = {mul_sum, acc_q[31:1]};
               b_d   = {1'b0, b_q[31:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(ITER - 1)) state_d = FIX;
         end
         FIX: begin
            if (op_q[1]) begin
               hi_d = negr_q ? -acc_q[63:32] : acc_q[63:32];
               lo_d = negq_q ? -acc_q[31:0]  : acc_q[31:0];
            end else begin
               {hi_d, lo_d} = negq_q ? -acc_q : acc_q;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Squash wins over any in-flight update, including the FIX write.
      if (flush_i && state_q != IDLE) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         op_q    <= 2'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         acc_q   <= 64'd0;
         cnt_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign hi_o        = hi_q;
   assign lo_o        = lo_q;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign stall_req_o = busy_o & (start_i | read_hilo_i | hi_we_i | lo_we_i);

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS core. Sits beside the ALU in EX and consumes the same `opA`/`opB` operand pair the operand-select stage produces for `mult`, `multu`, `div` and `divu`. Also services `mthi`, `mtlo`, `mfhi` and `mflo`. Raises a stall request whenever the pipeline would touch HI/LO or launch a new operation while one is in flight.

## Interface
Parameters:
- `ITER`, 32: iteration count of the serial datapath; fixed at 32 for the 32-bit ISA, exposed only for bench shortening.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch request from EX, qualified by the decoder for mult/multu/div/divu.
- `op`  in  2  operation select: 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `opA`  in  32  rs operand (multiplicand or dividend).
- `opB`  in  32  rt operand (multiplier or divisor).
- `hiWe`  in  1  mthi write enable.
- `loWe`  in  1  mtlo write enable.
- `wrData`  in  32  data for mthi/mtlo.
- `readHiLo`  in  1  EX holds mfhi or mflo.
- `flush`  in  1  squash in-flight operation (exception or redirect).
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse in the first cycle the new HI/LO is visible.
- `stallReq`  out  1  combinational: `busy & (start | readHiLo | hiWe | loWe)`.

## Operation
- FSM states: IDLE, CALC, FIX.
- Reset forces IDLE with `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0 and the counter at 0.
- IDLE:
  - On `start`, latch `op`. Latch |opA| and |opB| for signed ops; latch raw values for unsigned ops.
  - Record `negQ` = sign(opA) ^ sign(opB) and `negR` = sign(opA) for signed ops only.
  - Clear the 64-bit accumulator and the counter, then go to CALC.
- CALC: one radix-2 step per cycle. Leave after `ITER` cycles (counter 0..ITER-1), then go to FIX.
  - Multiply: shift-add. If the LSB of the multiplier is set, add the multiplicand to the upper half, then shift right by one.
  - Divide: restoring division. Shift the remainder:quotient pair left, then trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit.
- FIX: apply sign correction, write `hi`/`lo`, assert `busy` = 0 and pulse `done` on the next cycle, and return to IDLE.
  - Signed MULT negates the 64-bit product when `negQ` is set.
  - DIV negates the quotient when `negQ` is set and the remainder when `negR` is set.
  - Result placement: HI = product[63:32] or remainder; LO = product[31:0] or quotient.
- Divide by zero: `opB` = 0 forces HI = `opA` and LO = 32'hFFFFFFFF for both DIV and DIVU, bypassing sign correction.
- Signed DIV of 0x80000000 by 0xFFFFFFFF yields LO = 0x80000000 and HI = 0, which the unsigned-magnitude path produces naturally through wrap-around.
- `hiWe`/`loWe` in IDLE write `wrData` on the next edge. If `start` arrives in the same cycle, the write lands now and the operation result overwrites it at FIX.
- `hiWe`, `loWe` and `start` while busy are ignored. The pipeline is held by `stallReq` and re-presents the request once `busy` falls.
- `flush` in CALC or FIX returns the FSM to IDLE on the next edge. HI/LO are unchanged and no `done` pulse occurs. `flush` in IDLE blocks a same-cycle `start`.
- `reset` mid-operation behaves like a flush, plus the reset values above.

## Timing
- `start` is sampled at edge 0. `busy` is 1 from edge 0 onward.
- CALC spans edges 1..ITER. FIX is evaluated in the cycle after edge ITER.
- HI/LO update and `done` rises at edge ITER+1, which is 33 for the default. `busy` falls at the same edge.
- A back-to-back `start` is accepted in the cycle `done` is high.
- `stallReq` is combinational from registered `busy` and the inputs. There is no path from `start` into `busy`-gated logic within the same cycle.
- `hi`/`lo` are registered outputs. mfhi reads the registered value, so there is no bypass of in-flight results.

## Configuration
- `HILO_FAST_MUL_EN` defined: MULT/MULTU compute a single-cycle 64-bit product (signed or unsigned `*`) in IDLE and go directly to FIX. HI/LO update and `done` occur at edge 1, and `busy` is high for one cycle only. Divide is unchanged.
- `HILO_FAST_MUL_EN` undefined: all four operations use the serial 33-cycle path above. Result values are identical in both builds.

## Test plan
- Reset, then MULTU with opA = 0xFFFFFFFF and opB = 0xFFFFFFFF -> at edge 33, HI = 0xFFFFFFFE, LO = 0x00000001, one `done` pulse.
- MULT with opA = -3 (0xFFFFFFFD) and opB = 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Repeat with `HILO_FAST_MUL_EN` -> same values at edge 1.
- DIV with opA = -7 and opB = 2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). Then DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU with opA = 0x1234 and opB = 0 -> HI = 0x1234, LO = 0xFFFFFFFF.
- Start DIVU, assert `readHiLo` and `hiWe` at edge 5 -> `stallReq` = 1 until `done`, HI/LO not written by mthi; after `done`, mthi 0xAA writes HI = 0xAA next edge.
- Start MULT, assert `flush` at edge 10 -> `busy` = 0 at edge 11, HI/LO retain prior values, no `done`. A `start` at edge 12 completes normally.
